// File: rtl/spart_rx_cfg.sv
// ============================================================================
// Module  : spart_rx_cfg
// Brief   : Oversampling SPART receiver, configurable framing, FWFT rx FIFO
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module spart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          baud_tick,
  input  logic                          rxd,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rda,
  output logic                          framing_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int c_TW = $clog2(OVERSAMPLE);
  localparam int c_BW = $clog2(DATA_BITS + 1);
  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam int c_EW = DATA_BITS + 2;

  localparam logic [c_TW-1:0] c_HALF      = c_TW'(OVERSAMPLE / 2 - 1);
  localparam logic [c_TW-1:0] c_FULL      = c_TW'(OVERSAMPLE - 1);
  localparam logic [c_BW-1:0] c_LAST_DATA = c_BW'(DATA_BITS - 1);
  localparam logic [c_BW-1:0] c_LAST_STOP = c_BW'(STOP_BITS - 1);
  localparam logic [c_CW-1:0] c_DEPTH     = c_CW'(FIFO_DEPTH);
  localparam logic            c_ODD       = (PARITY_ODD != 0);
  localparam logic            c_PAR_EN    = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_sync;
  logic                  w_rxs;
  logic [c_TW-1:0]       r_tick_cnt;
  logic [c_BW-1:0]       r_bit_cnt;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_ferr;
  logic                  r_perr;
  logic                  r_push;
  logic [c_EW-1:0]       r_push_word;

  logic w_cnt_clr, w_cnt_inc, w_bit_clr, w_bit_inc;
  logic w_frame_start, w_smp_data, w_smp_par, w_smp_stop, w_done;

  // Two-flop synchroniser; idles high so reset never fakes a start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sync <= 2'b11;
    else      r_sync <= {r_sync[0], rxd};
  end
  assign w_rxs = r_sync[1];

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_clr     = 1'b0;
    w_cnt_inc     = 1'b0;
    w_bit_clr     = 1'b0;
    w_bit_inc     = 1'b0;
    w_frame_start = 1'b0;
    w_smp_data    = 1'b0;
    w_smp_par     = 1'b0;
    w_smp_stop    = 1'b0;
    w_done        = 1'b0;
    if (baud_tick) begin
      case (r_state)
        S_IDLE: begin
          if (!w_rxs) begin
            w_state_nxt   = S_START;
            w_cnt_clr     = 1'b1;
            w_bit_clr     = 1'b1;
            w_frame_start = 1'b1;
          end
        end
        S_START: begin
          if (r_tick_cnt == c_HALF) begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = w_rxs ? S_IDLE : S_DATA;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
        S_DATA: begin
          if (r_tick_cnt == c_FULL) begin
            w_cnt_clr  = 1'b1;
            w_smp_data = 1'b1;
            if (r_bit_cnt == c_LAST_DATA) begin
              w_bit_clr   = 1'b1;
              w_state_nxt = c_PAR_EN ? S_PARITY : S_STOP;
            end else begin
              w_bit_inc = 1'b1;
            end
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
        S_PARITY: begin
          if (r_tick_cnt == c_FULL) begin
            w_cnt_clr   = 1'b1;
            w_smp_par   = 1'b1;
            w_state_nxt = S_STOP;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
        S_STOP: begin
          if (r_tick_cnt == c_FULL) begin
            w_cnt_clr  = 1'b1;
            w_smp_stop = 1'b1;
            if (r_bit_cnt == c_LAST_STOP) begin
              w_bit_clr   = 1'b1;
              w_done      = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_bit_inc = 1'b1;
            end
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_ferr      <= 1'b0;
      r_perr      <= 1'b0;
      r_push      <= 1'b0;
      r_push_word <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_push  <= w_done;
      if (w_cnt_clr)      r_tick_cnt <= '0;
      else if (w_cnt_inc) r_tick_cnt <= r_tick_cnt + 1'b1;
      if (w_bit_clr)      r_bit_cnt <= '0;
      else if (w_bit_inc) r_bit_cnt <= r_bit_cnt + 1'b1;
      if (w_smp_data) r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
      if (w_frame_start) begin
        r_ferr <= 1'b0;
        r_perr <= 1'b0;
      end
      if (w_smp_par)  r_perr <= (^r_shift) ^ w_rxs ^ c_ODD;
      if (w_smp_stop) r_ferr <= r_ferr | ~w_rxs;
      // Last stop sample is folded in here since r_ferr updates in the same edge
      if (w_done)     r_push_word <= {r_shift, r_ferr | ~w_rxs, r_perr};
    end
  end

  logic [c_EW-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic            w_empty, w_full, w_pop, w_wr, w_ovf;
  logic [c_EW-1:0] w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_DEPTH);
  assign w_pop   = rd_en & ~w_empty;
  assign w_wr    = r_push & (~w_full | w_pop);
  assign w_ovf   = r_push & w_full & ~w_pop;
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_push_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      overrun  <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_ovf)        overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
    end
  end

  always_comb begin
    rx_data     = '0;
    framing_err = 1'b0;
    parity_err  = 1'b0;
    if (!w_empty) begin
      rx_data     = w_head[c_EW-1:2];
      framing_err = w_head[1];
      parity_err  = w_head[0];
    end
  end

  assign rda        = ~w_empty;
  assign fifo_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_spart_rx_cfg.sv
// ============================================================================
// Module  : tb_spart_rx_cfg
// Brief   : Directed bench for spart_rx_cfg (8N1 instance and 8E2 instance)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spart_rx_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, baud_tick;
  logic       rxd_a, rd_a, clr_a;
  logic       rxd_b, rd_b, clr_b;
  logic [7:0] data_a, data_b;
  logic       rda_a, ferr_a, perr_a, ovr_a;
  logic       rda_b, ferr_b, perr_b, ovr_b;
  logic [2:0] cnt_a, cnt_b;

  int total = 0;
  int bad   = 0;

  spart_rx_cfg #(
    .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
    .STOP_BITS(1), .OVERSAMPLE(16), .FIFO_DEPTH(4)
  ) u_dut_a (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rxd(rxd_a),
    .rd_en(rd_a), .clr_err(clr_a), .rx_data(data_a), .rda(rda_a),
    .framing_err(ferr_a), .parity_err(perr_a), .overrun(ovr_a),
    .fifo_count(cnt_a)
  );

  spart_rx_cfg #(
    .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
    .STOP_BITS(2), .OVERSAMPLE(16), .FIFO_DEPTH(4)
  ) u_dut_b (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rxd(rxd_b),
    .rd_en(rd_b), .clr_err(clr_b), .rx_data(data_b), .rda(rda_b),
    .framing_err(ferr_b), .parity_err(perr_b), .overrun(ovr_b),
    .fifo_count(cnt_b)
  );

  // One tick every 4 clocks -> 64 clocks per bit at OVERSAMPLE=16
  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input bit sel, input logic v);
    if (sel) rxd_b = v;
    else     rxd_a = v;
    repeat (64) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input logic par_en,
                            input logic par, input logic s1, input logic s2,
                            input logic two_stop);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (par_en) drive_bit(sel, par);
    drive_bit(sel, s1);
    if (two_stop) drive_bit(sel, s2);
    drive_bit(sel, 1'b1);
    drive_bit(sel, 1'b1);
  endtask

  task automatic send_a(input logic [7:0] d, input logic stop);
    send_frame(1'b0, d, 1'b0, 1'b0, stop, 1'b1, 1'b0);
  endtask

  task automatic pop_a();
    rd_a = 1'b1;
    @(negedge clk);
    rd_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop_b();
    rd_b = 1'b1;
    @(negedge clk);
    rd_b = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       s1;
    logic       s2;
    logic [7:0] exp_d;
    logic       exp_f;
    logic       exp_p;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // 8E2 frames: even parity bit makes the 9-bit popcount even
    vecs[0] = '{8'hA3, 1'b1, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b1};
    vecs[1] = '{8'hA3, 1'b0, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b0};
    vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 1'b0, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[5] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0};

    rst = 1'b0;
    rxd_a = 1'b1; rd_a = 1'b0; clr_a = 1'b0;
    rxd_b = 1'b1; rd_b = 1'b0; clr_b = 1'b0;
    repeat (3) @(negedge clk);
    check("reset rx_data", 32'(data_a), 32'h0);
    check("reset rda", 32'(rda_a), 32'h0);
    check("reset ferr", 32'(ferr_a), 32'h0);
    check("reset perr", 32'(perr_a), 32'h0);
    check("reset overrun", 32'(ovr_a), 32'h0);
    check("reset count", 32'(cnt_a), 32'h0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    send_a(8'h55, 1'b1);
    send_a(8'hA3, 1'b1);
    check("two frames rda", 32'(rda_a), 32'h1);
    check("two frames head", 32'(data_a), 32'h55);
    check("two frames ferr", 32'(ferr_a), 32'h0);
    check("two frames perr", 32'(perr_a), 32'h0);
    check("two frames count", 32'(cnt_a), 32'h2);
    pop_a();
    check("pop1 head", 32'(data_a), 32'hA3);
    check("pop1 count", 32'(cnt_a), 32'h1);
    pop_a();
    check("pop2 rda", 32'(rda_a), 32'h0);
    check("pop2 rx_data zero", 32'(data_a), 32'h0);
    pop_a();
    check("pop empty count", 32'(cnt_a), 32'h0);

    // False start: 5 ticks low is shorter than the mid-start sample point
    rxd_a = 1'b0;
    repeat (20) @(negedge clk);
    rxd_a = 1'b1;
    repeat (192) @(negedge clk);
    check("false start rda", 32'(rda_a), 32'h0);
    check("false start count", 32'(cnt_a), 32'h0);
    send_a(8'h5A, 1'b1);
    check("after false start head", 32'(data_a), 32'h5A);
    check("after false start count", 32'(cnt_a), 32'h1);
    pop_a();

    send_a(8'h3C, 1'b0);
    check("stop low ferr", 32'(ferr_a), 32'h1);
    check("stop low data", 32'(data_a), 32'h3C);
    check("stop low count", 32'(cnt_a), 32'h1);
    pop_a();
    check("stop low popped ferr", 32'(ferr_a), 32'h0);

    for (int i = 1; i <= 5; i++) send_a(8'(i), 1'b1);
    check("overflow count", 32'(cnt_a), 32'h4);
    check("overflow overrun", 32'(ovr_a), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      check("overflow pop data", 32'(data_a), 32'(i));
      pop_a();
    end
    check("overflow drained rda", 32'(rda_a), 32'h0);
    check("overrun sticky", 32'(ovr_a), 32'h1);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    check("overrun cleared", 32'(ovr_a), 32'h0);

    send_a(8'h11, 1'b1);
    send_a(8'h22, 1'b1);
    check("pre-reset count", 32'(cnt_a), 32'h2);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    rxd_a = 1'b1;
    repeat (32) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midframe reset rda", 32'(rda_a), 32'h0);
    check("midframe reset count", 32'(cnt_a), 32'h0);
    check("midframe reset rx_data", 32'(data_a), 32'h0);
    check("midframe reset ferr", 32'(ferr_a), 32'h0);
    check("midframe reset overrun", 32'(ovr_a), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b1);
    send_a(8'h7E, 1'b1);
    check("post-reset head", 32'(data_a), 32'h7E);
    check("post-reset count", 32'(cnt_a), 32'h1);
    check("post-reset ferr", 32'(ferr_a), 32'h0);
    pop_a();

    for (int i = 0; i < 6; i++) begin
      send_frame(1'b1, vecs[i].d, 1'b1, vecs[i].par, vecs[i].s1, vecs[i].s2, 1'b1);
      check($sformatf("vec%0d rda", i), 32'(rda_b), 32'h1);
      check($sformatf("vec%0d data", i), 32'(data_b), 32'(vecs[i].exp_d));
      check($sformatf("vec%0d ferr", i), 32'(ferr_b), 32'(vecs[i].exp_f));
      check($sformatf("vec%0d perr", i), 32'(perr_b), 32'(vecs[i].exp_p));
      check($sformatf("vec%0d count", i), 32'(cnt_b), 32'h1);
      pop_b();
      check($sformatf("vec%0d popped perr", i), 32'(perr_b), 32'h0);
      check($sformatf("vec%0d popped rda", i), 32'(rda_b), 32'h0);
    end
    check("8E2 overrun", 32'(ovr_b), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spart_rx_cfg.md
Name: spart_rx_cfg

Overview:
Parametrised oversampling SPART receiver and the successor to the fixed 8N1 receiver. It has configurable data width, parity and stop-bit count, and samples at mid-bit. Per-frame framing and parity status travels with each byte. Received frames are buffered in a small first-word-fall-through FIFO with sticky overrun detection. It sits between the baud generator, which supplies an oversample tick, and the bus interface, which pops received data.

Parameters:
DATA_BITS, 8, data bits per frame (legal 5..8), LSB first
PARITY_EN, 0, 1 = one parity bit follows the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)
STOP_BITS, 1, stop bits checked per frame (1 or 2)
OVERSAMPLE, 16, baud_tick pulses per bit period (even, 8..32)
FIFO_DEPTH, 4, receive FIFO entries (power of two, >=2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
baud_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate
rxd  input  1  serial input, idle high, asynchronous
rd_en  input  1  pop head FIFO entry (ignored when empty)
clr_err  input  1  clears sticky overrun
rx_data  output  DATA_BITS  head FIFO data (valid when rda=1)
rda  output  1  FIFO non-empty
framing_err  output  1  head entry had a stop bit sampled low
parity_err  output  1  head entry failed the parity check
overrun  output  1  sticky; a frame was dropped because the FIFO was full
fifo_count  output  $clog2(FIFO_DEPTH)+1  entries held

Behaviour:
- Reset (rst=0, async): sync flops=1, state IDLE, counters 0, FIFO empty; rx_data=0, rda=0, framing_err=0, parity_err=0, overrun=0, fifo_count=0.
- rxd is double-flopped; only the second-flop output (rxs) is used.
- The tick counter and bit counter advance only on baud_tick=1. Between ticks the FSM holds.
- IDLE: on a tick with rxs=0, go to START and clear the tick counter.
- START: on tick count OVERSAMPLE/2-1 (mid start bit), sample rxs.
  - rxs=1: false start; return to IDLE, nothing pushed.
  - rxs=0: go to DATA and clear the tick counter.
- DATA: every OVERSAMPLE ticks, sample rxs into the shift register, LSB first. After DATA_BITS samples, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: sample once after OVERSAMPLE ticks. perr = (XOR of data bits ^ sampled bit ^ PARITY_ODD) != 0. With PARITY_EN=0, perr=0.
- STOP: sample STOP_BITS times at OVERSAMPLE spacing. ferr = any stop sample was 0.
- Frame completion:
  - After the last stop sample, push {data, ferr, perr} in the next clk cycle and return to IDLE.
  - A new start bit can be detected from the second half of the stop bit onward.
  - rda rises 1 clk after the push cycle.
- The FSM does not abort on errors. A full frame is always consumed before returning to IDLE (except a false start).
- FIFO:
  - First-word fall-through: rx_data, framing_err and parity_err always show the head entry; all are 0 when empty.
  - rd_en while empty: no effect.
  - Push while full and no pop in the same cycle: the new frame is dropped, existing contents are unchanged, overrun=1.
  - Push and pop in the same cycle while full: legal; the count stays FIFO_DEPTH and overrun is not set.
  - Push and pop in the same cycle while empty: the push lands, the pop is ignored, count becomes 1.
  - Pointers wrap modulo FIFO_DEPTH.
- overrun clears only on clr_err=1 or reset. If clr_err and a new overrun occur in the same cycle, overrun=1 (set wins).
- Reset mid-frame: the frame in progress is discarded along with all FIFO contents.

Test Plan:
- 8N1, OVERSAMPLE=16; send 0x55, then 0xA3 -> rda=1, rx_data=0x55, errors 0, fifo_count=2; pulse rd_en -> rx_data=0xA3, fifo_count=1.
- rxd low for 5 ticks, then high -> no push, rda stays 0, FSM back in IDLE.
- PARITY_EN=1, even; send 0xA3 with parity=1 (correct 0) -> parity_err=1 with rx_data=0xA3; correct frame next -> parity_err=0 after pop.
- Send 0x3C with stop bit 0 -> framing_err=1, rx_data=0x3C; STOP_BITS=2 with second stop bit 0 -> framing_err=1.
- FIFO_DEPTH=4; send 5 frames 0x01..0x05 with no pops -> fifo_count=4, overrun=1, pops return 0x01..0x04; clr_err -> overrun=0.
- Assert rst at data bit 3 of a frame with FIFO holding 2 -> all outputs 0 immediately; next clean frame 0x7E is received correctly.
